// File: rtl/lsu_pkg.sv
// Shared types for the byte-serial load/store unit: access sizes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

   typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_RSVD} mem_size_t;

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR, RESP, ERR} lsu_state_t;

   function automatic logic [2:0] size_to_nbytes(input mem_size_t size);
      case (size)
         MEM_BYTE: size_to_nbytes = 3'd1;
         MEM_HALF: size_to_nbytes = 3'd2;
         MEM_WORD: size_to_nbytes = 3'd4;
         default:  size_to_nbytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Zero/sign extension of an assembled little-endian load result to 32 bits.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] data_i,
   input  mem_size_t   size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (size_i)
         MEM_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
         MEM_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
         default:  data_o = data_i;
      endcase
   end

endmodule

// File: rtl/byte_mem_lsu.sv
// Sequencer that serialises byte/half/word CPU loads and stores into
// per-byte accesses of an 8-bit synchronous RAM (one cycle read latency).
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request, RAM bus parked at addr 0
// RD_ISSUE | presenting read address addr+k, capturing byte k-1
// RD_DRAIN | no address, capturing the final read byte
// WR       | writing byte k of the store data to addr+k
// RESP     | one-cycle completion strobe
// ERR      | one-cycle completion strobe with error, no RAM access
module byte_mem_lsu
   import lsu_pkg::*;
#(
   parameter int L  = 32,
   parameter int AW = $clog2(L)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [31:0]   resp_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_ena,
   output logic [7:0]    mem_wr_data,
   input  logic [7:0]    mem_rd_data
);

   lsu_state_t    state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   mem_size_t     size_q;
   logic          sgn_q;
   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;
   logic [31:0]   ext_data;

   logic          accept;
   logic          req_legal;
   logic          last;
   logic [2:0]    req_nb;
   logic [AW+1:0] req_end;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   // End address is formed two bits wider than the RAM address so it cannot wrap.
   assign req_nb    = size_to_nbytes(mem_size_t'(req_size));
   assign req_end   = {2'b00, req_addr} + (AW+2)'(req_nb) - (AW+2)'(1);
   assign req_legal = (mem_size_t'(req_size) != MEM_RSVD) && (req_end <= (AW+2)'(L - 1));

   assign last      = (cnt_q == size_to_nbytes(size_q) - 3'd1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = !req_legal ? ERR : (req_we ? WR : RD_ISSUE);
         RD_ISSUE: if (last) state_d = RD_DRAIN;
         RD_DRAIN: state_d = RESP;
         WR:       if (last) state_d = RESP;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      resp_valid  = (state_q == RESP) || (state_q == ERR);
      resp_err    = (state_q == ERR);
      resp_rdata  = resp_rdata_q;
      mem_addr    = '0;
      mem_wr_ena  = 1'b0;
      mem_wr_data = 8'h00;
      case (state_q)
         RD_ISSUE: mem_addr = addr_q + AW'(cnt_q);
         WR: begin
            mem_addr    = addr_q + AW'(cnt_q);
            mem_wr_ena  = 1'b1;
            mem_wr_data = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   // Read data lags the address by one cycle, so byte k lands while cnt_q = k+1.
   always_comb begin
      rdata_d = rdata_q;
      if (accept) rdata_d = '0;
      if ((state_q == RD_ISSUE && cnt_q != 3'd0) || state_q == RD_DRAIN)
         rdata_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_rd_data;
   end

   lsu_load_extend u_ext (
      .data_i   (rdata_d),
      .size_i   (size_q),
      .signed_i (sgn_q),
      .data_o   (ext_data)
   );

   always_comb begin
      cnt_d        = 3'd0;
      resp_rdata_d = resp_rdata_q;
      if (state_q == RD_ISSUE || state_q == WR) cnt_d = cnt_q + 3'd1;
      if (state_d == RESP || state_d == ERR)
         resp_rdata_d = (state_q == RD_DRAIN) ? ext_data : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= MEM_BYTE;
         sgn_q        <= 1'b0;
         cnt_q        <= 3'd0;
         rdata_q      <= '0;
         resp_rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= mem_size_t'(req_size);
            sgn_q   <= req_signed;
         end
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_byte_mem_lsu.sv
// Bench for byte_mem_lsu paired with a behavioural 8x32 synchronous RAM.
module tb_byte_mem_lsu;

   localparam int L = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [4:0]  mem_addr;
   logic        mem_wr_ena;
   logic [7:0]  mem_wr_data, mem_rd_data;

   logic [7:0]  ram     [L];
   logic [7:0]  ref_mem [L];
   logic        ram_clear;

   int n_pass = 0;
   int n_total = 0;

   byte_mem_lsu #(.L(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < L; i++) ram[i] <= 8'h00;
      end else if (mem_wr_ena) begin
         ram[mem_addr] <= mem_wr_data;
      end
      mem_rd_data <= ram[mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input int a, input int n, input bit sg);
      longint v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[a+i]) << (8*i);
      if (sg && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
      return v[31:0];
   endfunction

   task automatic cmp_ram(input string nm);
      int bad = 0;
      for (int i = 0; i < L; i++) if (ram[i] !== ref_mem[i]) bad++;
      check(nm, 32'(bad), 32'd0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      check("accept", {31'd0, req_ready}, 32'd1);
   endtask

   // Issue one request, check cycle-by-cycle RAM traffic and the response
   // against the reference model, then update the model memory.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [4:0] ad, input logic [31:0] wd,
                         output int rc, output logic er, output logic [31:0] rd);
      int       n, exp_cyc;
      bit       legal, done;
      logic [31:0] exp_rd;
      n      = nbytes(sz);
      legal  = (sz != 2'd3) && (int'(ad) + n <= L);
      exp_rd = (legal && !we) ? model_load(int'(ad), n, sg) : 32'h0;
      exp_cyc = !legal ? 1 : (we ? n + 1 : n + 2);
      rc = 0; er = 1'b0; rd = 32'h0; done = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = ad; req_wdata = wd;
      @(negedge clk);
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = 5'($urandom); req_wdata = $urandom; req_signed = 1'($urandom);
      for (int cy = 1; cy <= 12 && !done; cy++) begin
         @(negedge clk);
         check("busy_ready", {31'd0, req_ready}, 32'd0);
         if (legal && cy <= n) begin
            check("mem_addr", {27'd0, mem_addr}, 32'(int'(ad) + cy - 1));
            check("mem_wr_ena", {31'd0, mem_wr_ena}, {31'd0, we});
            if (we) check("mem_wr_data", {24'd0, mem_wr_data}, {24'd0, 8'(wd >> (8*(cy-1)))});
         end else begin
            check("idle_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
         end
         if (resp_valid) begin
            done = 1; rc = cy; er = resp_err; rd = resp_rdata;
            check("resp_mem_addr", {27'd0, mem_addr}, 32'd0);
         end
      end
      check("resp_seen", {31'd0, done}, 32'd1);
      check("resp_cycle", 32'(rc), 32'(exp_cyc));
      check("resp_err", {31'd0, er}, {31'd0, !legal});
      check("resp_rdata", rd, exp_rd);
      if (legal && we) for (int i = 0; i < n; i++) ref_mem[int'(ad)+i] = 8'(wd >> (8*i));
      @(negedge clk);
      check("rdata_hold", resp_rdata, exp_rd);
      cmp_ram("ram_contents");
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        sg;
      logic [4:0]  ad;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      int          cyc;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int          rc, r1, r2, acc2, bad_ready, nresp;
      logic        er;
      logic [31:0] rd, rd1, rd2, exp1, exp2;
      logic [7:0]  pre11;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 5'd4,  32'hDEADBEEF, 1'b0, 32'h00000000, 5};
      vecs[1]  = '{1'b0, 2'd2, 1'b0, 5'd4,  32'h0,        1'b0, 32'hDEADBEEF, 6};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 5'd7,  32'h0,        1'b0, 32'hFFFFFFDE, 3};
      vecs[3]  = '{1'b0, 2'd0, 1'b0, 5'd7,  32'h0,        1'b0, 32'h000000DE, 3};
      vecs[4]  = '{1'b1, 2'd1, 1'b0, 5'd5,  32'hABCD1234, 1'b0, 32'h00000000, 3};
      vecs[5]  = '{1'b0, 2'd1, 1'b1, 5'd5,  32'h0,        1'b0, 32'h00001234, 4};
      vecs[6]  = '{1'b0, 2'd0, 1'b0, 5'd4,  32'h0,        1'b0, 32'h000000EF, 3};
      vecs[7]  = '{1'b0, 2'd0, 1'b0, 5'd7,  32'h0,        1'b0, 32'h000000DE, 3};
      vecs[8]  = '{1'b1, 2'd1, 1'b0, 5'd5,  32'h55558001, 1'b0, 32'h00000000, 3};
      vecs[9]  = '{1'b0, 2'd1, 1'b1, 5'd5,  32'h0,        1'b0, 32'hFFFF8001, 4};
      vecs[10] = '{1'b1, 2'd2, 1'b0, 5'd29, 32'hCAFEF00D, 1'b1, 32'h00000000, 1};
      vecs[11] = '{1'b1, 2'd2, 1'b0, 5'd28, 32'h11223344, 1'b0, 32'h00000000, 5};
      vecs[12] = '{1'b0, 2'd2, 1'b0, 5'd28, 32'h0,        1'b0, 32'h11223344, 6};
      vecs[13] = '{1'b0, 2'd3, 1'b0, 5'd0,  32'h0,        1'b1, 32'h00000000, 1};
      vecs[14] = '{1'b0, 2'd0, 1'b1, 5'd31, 32'h0,        1'b0, 32'h00000011, 3};
      vecs[15] = '{1'b0, 2'd1, 1'b0, 5'd31, 32'h0,        1'b1, 32'h00000000, 1};
      vecs[16] = '{1'b0, 2'd2, 1'b1, 5'd29, 32'h0,        1'b1, 32'h00000000, 1};

      for (int i = 0; i < L; i++) ref_mem[i] = 8'h00;
      rst = 1'b1; ram_clear = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 5'd0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_rst", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ram_clear = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
      check("rst_mem_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
      check("rst_mem_wr_data", {24'd0, mem_wr_data}, 32'd0);

      for (int i = 0; i < 17; i++) begin
         do_req(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd, rc, er, rd);
         check($sformatf("vec%0d_cycle", i), 32'(rc), 32'(vecs[i].cyc));
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].err});
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      end
      check("ram4_kept", {24'd0, ram[4]}, 32'hEF);
      check("ram7_kept", {24'd0, ram[7]}, 32'hDE);

      // Back-to-back: valid held high, second request queued behind the first.
      exp1 = model_load(4, 4, 1'b0);
      exp2 = model_load(7, 1, 1'b1);
      r1 = 0; r2 = 0; acc2 = 0; bad_ready = 0; rd1 = 0; rd2 = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 5'd4;
      @(negedge clk);
      wait_ready();
      @(posedge clk); #1;
      req_size = 2'd0; req_signed = 1'b1; req_addr = 5'd7;
      for (int cy = 1; cy <= 20 && r2 == 0; cy++) begin
         @(negedge clk);
         if (resp_valid && r1 == 0) begin r1 = cy; rd1 = resp_rdata; end
         else if (resp_valid && acc2 != 0) begin r2 = cy; rd2 = resp_rdata; end
         if (req_ready && (r1 == 0 || (acc2 != 0 && cy > acc2))) bad_ready++;
         if (req_ready && acc2 == 0 && r1 != 0) acc2 = cy;
         @(posedge clk); #1;
         if (acc2 == cy) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      check("b2b_resp1_cycle", 32'(r1), 32'd6);
      check("b2b_accept2_cycle", 32'(acc2), 32'(r1 + 1));
      check("b2b_resp2_cycle", 32'(r2), 32'(acc2 + 3));
      check("b2b_rdata1", rd1, exp1);
      check("b2b_rdata2", rd2, exp2);
      check("b2b_ready_busy", 32'(bad_ready), 32'd0);

      // Reset in cycle 3 of a word store: three bytes land, no response.
      pre11 = ram[11];
      nresp = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 5'd8; req_wdata = 32'hAABBCCDD;
      @(negedge clk);
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); if (resp_valid) nresp++;
      @(posedge clk); #1;
      @(negedge clk); if (resp_valid) nresp++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); if (resp_valid) nresp++;
      check("rst_c3_wr_ena", {31'd0, mem_wr_ena}, 32'd1);
      check("rst_c3_addr", {27'd0, mem_addr}, 32'd10);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) nresp++;
         @(negedge clk);
      end
      check("abort_no_resp", 32'(nresp), 32'd0);
      check("abort_ram8", {24'd0, ram[8]}, 32'hDD);
      check("abort_ram9", {24'd0, ram[9]}, 32'hCC);
      check("abort_ram10", {24'd0, ram[10]}, 32'hBB);
      check("abort_ram11", {24'd0, ram[11]}, {24'd0, pre11});
      ref_mem[8] = 8'hDD; ref_mem[9] = 8'hCC; ref_mem[10] = 8'hBB;
      cmp_ram("abort_ram_all");

      for (int t = 0; t < 200; t++) begin
         do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, L - 1)), $urandom, rc, er, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
